regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Architectural register file with a per-register pending-write scoreboard.
- Serves the decode stage's two read ports: rs1/rs2 values plus outstanding-write counts.
- Increments a register's count when decode pulses write_rd_wcnt.
- Accepts writeback from the execute/memory side, which writes the value and decrements the count.
- Decode stalls while a source count is nonzero.

Parameters:
- REG_CNT, 32, number of architectural registers (x0 hardwired to zero).
- LOG_REG_CNT, 5, register index width.
- CNT_W, 4, width of each internal pending-write counter. Counts are zero-extended to 32 bits on output.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global enable; 0 freezes all state
- read_rs1  in  1  rs1 read request, level
- rs1_id  in  LOG_REG_CNT  rs1 index
- rs1_val_raw  out  32  rs1 value
- rs1_wcnt  out  32  pending writes to rs1
- read_rs2  in  1  rs2 read request, level
- rs2_id  in  LOG_REG_CNT  rs2 index
- rs2_val_raw  out  32  rs2 value
- rs2_wcnt  out  32  pending writes to rs2
- write_rd_wcnt  in  1  one-cycle pulse: reserve a write to rd_id
- rd_id  in  LOG_REG_CNT  destination index for the reservation
- wb_en  in  1  one-cycle writeback strobe
- wb_id  in  LOG_REG_CNT  writeback index
- wb_val  in  32  writeback data
- sb_err  out  1  sticky: counter overflow or underflow detected

Behaviour:
- Reset (async, on rst high): all registers = 0, all counters = 0, sb_err = 0. The read outputs therefore read 0 while reset is asserted.
- Read ports are combinational from current state:
  - rs1_val_raw = read_rs1 ? reg[rs1_id] : 0
  - rs1_wcnt = read_rs1 ? {zero-ext cnt[rs1_id]} : 0
  - rs2 ports are identical with read_rs2/rs2_id.
- Index 0 always returns value 0 and count 0.
- No write-to-read bypass: a writeback at edge N becomes visible only after edge N. The count stays nonzero through cycle N, so decode never samples a stale value as ready.
- State updates happen only on the posedge when rdy=1 and rst=0. When rdy=0, registers, counters and sb_err hold.
- Reservation: write_rd_wcnt=1 and rd_id!=0 → cnt[rd_id] += 1.
- Writeback: wb_en=1 and wb_id!=0 → reg[wb_id] <= wb_val and cnt[wb_id] -= 1.
- Same index reserved and written back in one cycle: the count is unchanged (net 0) and reg is updated.
- Different indices in the same cycle: both updates apply independently.
- Overflow: an increment with cnt = 2^CNT_W-1 leaves cnt saturated and sets sb_err.
- Underflow: a writeback with cnt = 0 still writes the value, leaves cnt at 0, and sets sb_err.
- Simultaneous increment and decrement never raises sb_err.
- Index 0: reservations and writebacks to x0 are ignored entirely. No value change, no count change, no error.
- sb_err clears only on rst.
- Reset mid-operation: all pending counts are discarded immediately (async). The read outputs reflect the reset state in the same cycle.
- Multiple outstanding writes to one register are allowed. The value visible after the last decrement is the last-written value; ordering is the writeback producer's responsibility.

Test Plan:
- Reset, then read_rs1=1 with rs1_id=5 and read_rs2=1 with rs2_id=0 → rs1_val_raw=0, rs1_wcnt=0, rs2_val_raw=0, rs2_wcnt=0. With read_rs1=0 → rs1 outputs 0 regardless of state.
- Reservation then writeback:
  - Pulse write_rd_wcnt with rd_id=7 → rs1_wcnt reads 1 for rs1_id=7.
  - Two cycles later, wb_en with wb_id=7 and wb_val=0xDEADBEEF.
  - In the writeback cycle, rs1_wcnt=1 and the old value is still shown.
  - The next cycle reads rs1_wcnt=0 and rs1_val_raw=0xDEADBEEF.
- Same-cycle reservation and writeback: with cnt[3]=1, assert write_rd_wcnt (rd_id=3) and wb_en (wb_id=3, wb_val=0x12) together → cnt[3] stays 1, reg[3]=0x12, sb_err=0.
- Ignored operations:
  - x0 reservation plus writeback of 0xFFFFFFFF → rs1_id=0 reads value 0, count 0, sb_err=0.
  - rdy=0 during a pulse on register 9 → cnt[9] unchanged.
- Error cases:
  - 16 reservations to x4 with CNT_W=4 → cnt saturates at 15 and sb_err=1.
  - After reset, writeback to x2 with count 0 → reg[2] written and sb_err=1.
  - Async rst asserted mid-cycle → all counts and sb_err read 0 before the next clock edge.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file with a per-register pending-write
// scoreboard. Decode reserves writes (count up), writeback retires them
// (value written, count down). Reads are combinational from current state,
// with no write-to-read bypass, so a register is never shown ready early.
module regfile_sb #(
    parameter int REG_CNT     = 32,
    parameter int LOG_REG_CNT = 5,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   read_rs1,
    input  logic [LOG_REG_CNT-1:0] rs1_id,
    output logic [31:0]            rs1_val_raw,
    output logic [31:0]            rs1_wcnt,
    input  logic                   read_rs2,
    input  logic [LOG_REG_CNT-1:0] rs2_id,
    output logic [31:0]            rs2_val_raw,
    output logic [31:0]            rs2_wcnt,
    input  logic                   write_rd_wcnt,
    input  logic [LOG_REG_CNT-1:0] rd_id,
    input  logic                   wb_en,
    input  logic [LOG_REG_CNT-1:0] wb_id,
    input  logic [31:0]            wb_val,
    output logic                   sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Per-register views gathered from the generate blocks below.
    logic [31:0]      w_val [REG_CNT];
    logic [CNT_W-1:0] w_cnt [REG_CNT];
    logic [REG_CNT-1:0] w_ovf;
    logic [REG_CNT-1:0] w_unf;
    logic               r_sb_err;

    genvar gi;
    generate
        for (gi = 0; gi < REG_CNT; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // x0 has no storage: reads zero, ignores reservations and writebacks.
                assign w_val[gi] = '0;
                assign w_cnt[gi] = '0;
                assign w_ovf[gi] = 1'b0;
                assign w_unf[gi] = 1'b0;
            end else begin : g_live
                logic [31:0]      r_val;
                logic [CNT_W-1:0] r_cnt;
                logic             w_inc;
                logic             w_dec;

                assign w_inc = write_rd_wcnt && (rd_id == LOG_REG_CNT'(gi));
                assign w_dec = wb_en && (wb_id == LOG_REG_CNT'(gi));

                // A simultaneous reserve+retire nets to zero and can never fault.
                assign w_ovf[gi] = w_inc && !w_dec && (r_cnt == CNT_MAX);
                assign w_unf[gi] = w_dec && !w_inc && (r_cnt == '0);

                // Register value: writeback always lands, even on a count underflow.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_val <= '0;
                    end else if (rdy && w_dec) begin
                        r_val <= wb_val;
                    end
                end

                // Pending-write counter, saturating at both ends.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_cnt <= '0;
                    end else if (rdy) begin
                        if (w_inc && !w_dec && (r_cnt != CNT_MAX)) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end

                assign w_val[gi] = r_val;
                assign w_cnt[gi] = r_cnt;
            end
        end
    endgenerate

    // Sticky scoreboard error flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_err <= 1'b0;
        end else if (rdy && ((|w_ovf) || (|w_unf))) begin
            r_sb_err <= 1'b1;
        end
    end

    assign sb_err = r_sb_err;

    // Combinational read ports; a deasserted request forces zeros.
    always_comb begin
        rs1_val_raw = '0;
        rs1_wcnt    = '0;
        rs2_val_raw = '0;
        rs2_wcnt    = '0;
        if (read_rs1) begin
            rs1_val_raw = w_val[rs1_id];
            rs1_wcnt    = {{(32-CNT_W){1'b0}}, w_cnt[rs1_id]};
        end
        if (read_rs2) begin
            rs2_val_raw = w_val[rs2_id];
            rs2_wcnt    = {{(32-CNT_W){1'b0}}, w_cnt[rs2_id]};
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Inputs change on the falling edge and
// outputs are sampled just before the next falling edge, away from posedge.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        read_rs1;
    logic [4:0]  rs1_id;
    logic [31:0] rs1_val_raw;
    logic [31:0] rs1_wcnt;
    logic        read_rs2;
    logic [4:0]  rs2_id;
    logic [31:0] rs2_val_raw;
    logic [31:0] rs2_wcnt;
    logic        write_rd_wcnt;
    logic [4:0]  rd_id;
    logic        wb_en;
    logic [4:0]  wb_id;
    logic [31:0] wb_val;
    logic        sb_err;

    int checks;
    int errors;

    regfile_sb #(.REG_CNT(32), .LOG_REG_CNT(5), .CNT_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .read_rs1      (read_rs1),
        .rs1_id        (rs1_id),
        .rs1_val_raw   (rs1_val_raw),
        .rs1_wcnt      (rs1_wcnt),
        .read_rs2      (read_rs2),
        .rs2_id        (rs2_id),
        .rs2_val_raw   (rs2_val_raw),
        .rs2_wcnt      (rs2_wcnt),
        .write_rd_wcnt (write_rd_wcnt),
        .rd_id         (rd_id),
        .wb_en         (wb_en),
        .wb_id         (wb_id),
        .wb_val        (wb_val),
        .sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next falling edge and drop all one-cycle strobes.
    task automatic next_cycle();
        @(negedge clk);
        write_rd_wcnt = 1'b0;
        wb_en         = 1'b0;
    endtask

    task automatic test_reset();
        read_rs1 = 1'b1; rs1_id = 5'd5;
        read_rs2 = 1'b1; rs2_id = 5'd0;
        #1;
        checks++;
        if (rs1_val_raw !== 32'd0 || rs1_wcnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_hold_rs1 got val=%h cnt=%0d want 0/0", rs1_val_raw, rs1_wcnt);
        end
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        checks++;
        if (rs1_val_raw !== 32'd0 || rs1_wcnt !== 32'd0 || rs2_val_raw !== 32'd0 || rs2_wcnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_reads got %h/%0d %h/%0d want all 0", rs1_val_raw, rs1_wcnt, rs2_val_raw, rs2_wcnt);
        end
        checks++;
        if (sb_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_sb_err got %b want 0", sb_err);
        end
        $display("test_reset done");
    endtask

    task automatic test_reserve_wb();
        write_rd_wcnt = 1'b1; rd_id = 5'd7;
        next_cycle();
        rs1_id = 5'd7;
        #1;
        checks++;
        if (rs1_wcnt !== 32'd1 || rs1_val_raw !== 32'd0) begin
            errors++;
            $display("FAIL reserve_cnt got cnt=%0d val=%h want 1/0", rs1_wcnt, rs1_val_raw);
        end
        read_rs1 = 1'b0;
        #1;
        checks++;
        if (rs1_val_raw !== 32'd0 || rs1_wcnt !== 32'd0) begin
            errors++;
            $display("FAIL read_gate got val=%h cnt=%0d want 0/0", rs1_val_raw, rs1_wcnt);
        end
        read_rs1 = 1'b1;
        next_cycle();
        wb_en = 1'b1; wb_id = 5'd7; wb_val = 32'hDEADBEEF;
        #1;
        checks++;
        if (rs1_wcnt !== 32'd1 || rs1_val_raw !== 32'd0) begin
            errors++;
            $display("FAIL wb_no_bypass got cnt=%0d val=%h want 1/0", rs1_wcnt, rs1_val_raw);
        end
        next_cycle();
        checks++;
        if (rs1_wcnt !== 32'd0 || rs1_val_raw !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL wb_visible got cnt=%0d val=%h want 0/deadbeef", rs1_wcnt, rs1_val_raw);
        end
        $display("test_reserve_wb done");
    endtask

    task automatic test_same_cycle();
        write_rd_wcnt = 1'b1; rd_id = 5'd3;
        next_cycle();
        write_rd_wcnt = 1'b1; rd_id = 5'd3;
        wb_en = 1'b1; wb_id = 5'd3; wb_val = 32'h12;
        next_cycle();
        rs1_id = 5'd3;
        #1;
        checks++;
        if (rs1_wcnt !== 32'd1 || rs1_val_raw !== 32'h12 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL same_idx got cnt=%0d val=%h err=%b want 1/12/0", rs1_wcnt, rs1_val_raw, sb_err);
        end
        // Different indices in one cycle: retire x3, reserve x10.
        write_rd_wcnt = 1'b1; rd_id = 5'd10;
        wb_en = 1'b1; wb_id = 5'd3; wb_val = 32'h34;
        next_cycle();
        rs2_id = 5'd10;
        #1;
        checks++;
        if (rs1_wcnt !== 32'd0 || rs1_val_raw !== 32'h34 || rs2_wcnt !== 32'd1 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL diff_idx got x3=%0d/%h x10=%0d err=%b want 0/34 1 0", rs1_wcnt, rs1_val_raw, rs2_wcnt, sb_err);
        end
        $display("test_same_cycle done");
    endtask

    task automatic test_x0();
        write_rd_wcnt = 1'b1; rd_id = 5'd0;
        wb_en = 1'b1; wb_id = 5'd0; wb_val = 32'hFFFFFFFF;
        next_cycle();
        wb_en = 1'b1; wb_id = 5'd0; wb_val = 32'hFFFFFFFF;
        next_cycle();
        rs1_id = 5'd0;
        #1;
        checks++;
        if (rs1_val_raw !== 32'd0 || rs1_wcnt !== 32'd0 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL x0_ignored got val=%h cnt=%0d err=%b want 0/0/0", rs1_val_raw, rs1_wcnt, sb_err);
        end
        $display("test_x0 done");
    endtask

    task automatic test_rdy();
        rdy = 1'b0;
        write_rd_wcnt = 1'b1; rd_id = 5'd9;
        next_cycle();
        wb_en = 1'b1; wb_id = 5'd7; wb_val = 32'h55;
        next_cycle();
        rs1_id = 5'd9; rs2_id = 5'd7;
        #1;
        checks++;
        if (rs1_wcnt !== 32'd0 || rs2_val_raw !== 32'hDEADBEEF || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL rdy_hold got cnt9=%0d val7=%h err=%b want 0/deadbeef/0", rs1_wcnt, rs2_val_raw, sb_err);
        end
        rdy = 1'b1;
        $display("test_rdy done");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 15; i++) begin
            write_rd_wcnt = 1'b1; rd_id = 5'd4;
            next_cycle();
        end
        rs1_id = 5'd4;
        #1;
        checks++;
        if (rs1_wcnt !== 32'd15 || sb_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_full got cnt=%0d err=%b want 15/0", rs1_wcnt, sb_err);
        end
        write_rd_wcnt = 1'b1; rd_id = 5'd4;
        next_cycle();
        checks++;
        if (rs1_wcnt !== 32'd15 || sb_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat got cnt=%0d err=%b want 15/1", rs1_wcnt, sb_err);
        end
        // A clean retire afterwards must not clear the sticky flag.
        wb_en = 1'b1; wb_id = 5'd4; wb_val = 32'h44;
        next_cycle();
        checks++;
        if (rs1_wcnt !== 32'd14 || sb_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got cnt=%0d err=%b want 14/1", rs1_wcnt, sb_err);
        end
        $display("test_overflow done");
    endtask

    task automatic test_async_reset();
        rs1_id = 5'd4; rs2_id = 5'd10;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rs1_wcnt !== 32'd0 || rs2_wcnt !== 32'd0 || sb_err !== 1'b0 || rs1_val_raw !== 32'd0) begin
            errors++;
            $display("FAIL async_rst got cnt4=%0d cnt10=%0d err=%b val4=%h want 0/0/0/0", rs1_wcnt, rs2_wcnt, sb_err, rs1_val_raw);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_async_reset done");
    endtask

    task automatic test_underflow();
        wb_en = 1'b1; wb_id = 5'd2; wb_val = 32'hA5A5_0002;
        next_cycle();
        rs1_id = 5'd2;
        #1;
        checks++;
        if (rs1_val_raw !== 32'hA5A5_0002 || rs1_wcnt !== 32'd0 || sb_err !== 1'b1) begin
            errors++;
            $display("FAIL underflow got val=%h cnt=%0d err=%b want a5a50002/0/1", rs1_val_raw, rs1_wcnt, sb_err);
        end
        $display("test_underflow done");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; rdy = 1'b1;
        read_rs1 = 1'b0; rs1_id = '0;
        read_rs2 = 1'b0; rs2_id = '0;
        write_rd_wcnt = 1'b0; rd_id = '0;
        wb_en = 1'b0; wb_id = '0; wb_val = '0;

        test_reset();
        test_reserve_wb();
        test_same_cycle();
        test_x0();
        test_rdy();
        test_overflow();
        test_async_reset();
        test_underflow();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
